prt_riscv_cpu_regfile: RTL

PRT_RISCV_CPU_REGFILE -- requirements
Module: prt_riscv_cpu_regfile

---
 rtl/prt_riscv_cpu_regfile.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/prt_riscv_cpu_regfile.sv
// prt_riscv_cpu_regfile
//   RISC-V integer register file with a per-register "load pending" scoreboard
//   bit and two registered read ports. After reset a sweep FSM zeroes every
//   register, one per cycle, before accesses are accepted (RDY_OUT high).
//   Register 0 and any index >= P_REGS always read as zero and are never
//   written or marked pending.
//
// Parameters
//   P_REGS : number of registers (2..32)
//   P_IDX  : index width, clog2(P_REGS)
//   P_DAT  : register data width (8..64)
//
// Ports
//   CLK_IN       : clock, rising edge
//   RST_IN       : asynchronous active-low reset
//   RDY_OUT      : high once the zeroing sweep is done
//   RD_IDX_IN    : destination index      RD_DAT_IN : destination data
//   RD_WR_IN     : destination write strobe (clears the pending bit)
//   PEND_IDX_IN  : index to mark pending  PEND_SET_IN : mark strobe
//   RSx_IDX_IN   : read index (x = 1, 2)
//   RSx_DAT_OUT  : registered read data   RSx_PEND_OUT : registered pending bit
//
// Configuration macro
//   PRT_RISCV_CPU_REGFILE_BYPASS_EN : when defined, a read of the register
//   being written in the same cycle returns the new data and the post-update
//   pending state; otherwise it returns the old contents.

module prt_riscv_cpu_regfile #(
  parameter int P_REGS = 32,
  parameter int P_IDX  = 5,
  parameter int P_DAT  = 32
) (
  input  logic             CLK_IN,
  input  logic             RST_IN,
  output logic             RDY_OUT,
  input  logic [P_IDX-1:0] RD_IDX_IN,
  input  logic [P_DAT-1:0] RD_DAT_IN,
  input  logic             RD_WR_IN,
  input  logic [P_IDX-1:0] PEND_IDX_IN,
  input  logic             PEND_SET_IN,
  input  logic [P_IDX-1:0] RS1_IDX_IN,
  output logic [P_DAT-1:0] RS1_DAT_OUT,
  output logic             RS1_PEND_OUT,
  input  logic [P_IDX-1:0] RS2_IDX_IN,
  output logic [P_DAT-1:0] RS2_DAT_OUT,
  output logic             RS2_PEND_OUT
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [P_IDX-1:0] LAST_IDX = P_IDX'(P_REGS - 1);
  localparam logic [P_IDX:0]   NUM_REGS = (P_IDX + 1)'(P_REGS);

  state_t            state_q, state_d;
  logic [P_IDX-1:0]  cnt_q, cnt_d;
  logic              run;
  logic              wr_en, pend_en;
  logic [P_REGS-1:0] pend_q, pend_d;
  logic [P_DAT-1:0]  rs1_dat_d, rs2_dat_d;
  logic              rs1_pend_d, rs2_pend_d;

  // Kept in LUTs so both read ports can look up asynchronously; no reset,
  // the sweep is the only thing that clears it.
  (* ram_style = "distributed" *) logic [P_DAT-1:0] regs [P_REGS];

  // Index 0 is hardwired zero and indices past the array do not exist.
  function automatic logic idx_ok(input logic [P_IDX-1:0] idx);
    return (idx != '0) && ({1'b0, idx} < NUM_REGS);
  endfunction

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep walks cnt over every register once, then parks in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == LAST_IDX) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + P_IDX'(1);
      end
    end
  end

  assign run     = (state_q == ST_RUN);
  assign RDY_OUT = run;
  assign wr_en   = run && RD_WR_IN && idx_ok(RD_IDX_IN);
  assign pend_en = run && PEND_SET_IN && idx_ok(PEND_IDX_IN);

  // Set is applied after clear so a load issued in the same cycle as a
  // writeback to the same register leaves it pending.
  always_comb begin
    pend_d = pend_q;
    if (wr_en) begin
      pend_d[RD_IDX_IN] = 1'b0;
    end
    if (pend_en) begin
      pend_d[PEND_IDX_IN] = 1'b1;
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (!run) begin
      regs[cnt_q] <= '0;
    end else if (wr_en) begin
      regs[RD_IDX_IN] <= RD_DAT_IN;
    end
  end

  // Read lookup; forced to zero while sweeping or for invalid indices.
  always_comb begin
    rs1_dat_d  = '0;
    rs1_pend_d = 1'b0;
    rs2_dat_d  = '0;
    rs2_pend_d = 1'b0;
    if (run && idx_ok(RS1_IDX_IN)) begin
      rs1_dat_d  = regs[RS1_IDX_IN];
      rs1_pend_d = pend_q[RS1_IDX_IN];
`ifdef PRT_RISCV_CPU_REGFILE_BYPASS_EN
      if (wr_en && (RS1_IDX_IN == RD_IDX_IN)) begin
        rs1_dat_d  = RD_DAT_IN;
        rs1_pend_d = pend_d[RS1_IDX_IN];
      end
`endif
    end
    if (run && idx_ok(RS2_IDX_IN)) begin
      rs2_dat_d  = regs[RS2_IDX_IN];
      rs2_pend_d = pend_q[RS2_IDX_IN];
`ifdef PRT_RISCV_CPU_REGFILE_BYPASS_EN
      if (wr_en && (RS2_IDX_IN == RD_IDX_IN)) begin
        rs2_dat_d  = RD_DAT_IN;
        rs2_pend_d = pend_d[RS2_IDX_IN];
      end
`endif
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      RS1_DAT_OUT  <= '0;
      RS1_PEND_OUT <= 1'b0;
      RS2_DAT_OUT  <= '0;
      RS2_PEND_OUT <= 1'b0;
    end else begin
      RS1_DAT_OUT  <= rs1_dat_d;
      RS1_PEND_OUT <= rs1_pend_d;
      RS2_DAT_OUT  <= rs2_dat_d;
      RS2_PEND_OUT <= rs2_pend_d;
    end
  end

endmodule
